// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low patterns (bit0=a .. bit6=g) and scan reader state type.
// Imported by the display driver side and by the scan reader.
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG7_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG7_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG7_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG7_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG7_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG7_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG7_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG7_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG7_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG7_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG7_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG7_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG7_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG7_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG7_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG7_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG7_BLANK = 7'b1111111;

    localparam logic [SEG_W-1:0] SEG7_TABLE [16] = '{
        SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5, SEG7_6, SEG7_7,
        SEG7_8, SEG7_9, SEG7_A, SEG7_B, SEG7_C, SEG7_D, SEG7_E, SEG7_F
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } seg7_state_e;

    function automatic logic [SEG_W-1:0] seg7_encode(input logic [3:0] nibble);
        return SEG7_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_pattern_match.sv
// Combinational inverse decode of an active-low 7-segment pattern to a hex nibble.
// hit flags a table match; blank flags the all-off pattern.
module seg7_pattern_match
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [3:0]       nibble,
    output logic             hit,
    output logic             blank
);

    always_comb begin
        nibble = 4'd0;
        hit    = 1'b0;
        blank  = (pattern == SEG7_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG7_TABLE[i]) begin
                nibble = 4'(i);
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed active-low 7-segment bus into a per-digit nibble bank.
// Optional decimal-point capture is built when SEG7_SCAN_READER_DP_EN is defined.
//
// state  | meaning
// IDLE   | bus fully deselected, nothing to capture
// SETTLE | counting identical synchronized samples
// DONE   | value evaluated once, waiting for the bus to change
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [SEG_W-1:0]        segs_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
`ifdef SEG7_SCAN_READER_DP_EN
    input  logic                    dp_in,
    output logic [NUM_DIGITS-1:0]   digit_dp,
`endif
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update_pulse,
    output logic [2:0]              update_idx,
    output logic                    err_pulse,
    output logic [7:0]              err_count
);

`ifdef SEG7_SCAN_READER_DP_EN
    localparam int DP_W = 1;
`else
    localparam int DP_W = 0;
`endif
    localparam int         VEC_W       = DP_W + NUM_DIGITS + SEG_W;
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    logic [VEC_W-1:0]        bus_raw;
    logic [VEC_W-1:0]        sync1_q;
    logic [VEC_W-1:0]        sync2_q;
    logic [VEC_W-1:0]        cmp_q;
    seg7_state_e             state_q;
    logic [7:0]              cnt_q;
    logic [7:0]              cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   valid_q;
    logic                    upd_q;
    logic [2:0]              upd_idx_q;
    logic                    err_q;
    logic [7:0]              err_cnt_q;

    logic [SEG_W-1:0]        cur_segs;
    logic [NUM_DIGITS-1:0]   cur_sel;
    logic [3:0]              match_nibble;
    logic                    match_hit;
    logic                    match_blank;
    logic [3:0]              sel_low_cnt;
    logic [2:0]              sel_low_idx;
    logic                    bus_changed;

`ifdef SEG7_SCAN_READER_DP_EN
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   dp_q;
    assign bus_raw  = {dp_in, dig_sel_n, segs_in};
    assign cur_dp   = sync2_q[VEC_W-1];
    assign digit_dp = dp_q;
`else
    assign bus_raw  = {dig_sel_n, segs_in};
`endif

    assign cur_segs    = sync2_q[SEG_W-1:0];
    assign cur_sel     = sync2_q[SEG_W +: NUM_DIGITS];
    assign bus_changed = (sync2_q != cmp_q);
    assign cnt_d       = cnt_q + 8'd1;

    seg7_pattern_match u_match (
        .pattern (cur_segs),
        .nibble  (match_nibble),
        .hit     (match_hit),
        .blank   (match_blank)
    );

    always_comb begin
        sel_low_cnt = 4'd0;
        sel_low_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!cur_sel[i]) begin
                sel_low_cnt = sel_low_cnt + 4'd1;
                sel_low_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            cmp_q     <= '1;
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            digits_q  <= '0;
            valid_q   <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= 3'd0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
`ifdef SEG7_SCAN_READER_DP_EN
            dp_q      <= '0;
`endif
        end else begin
            sync1_q <= bus_raw;
            sync2_q <= sync1_q;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;

            // Any change restarts qualification, whatever state we are in.
            if (bus_changed) begin
                cmp_q   <= sync2_q;
                cnt_q   <= 8'd0;
                state_q <= (&cur_sel) ? ST_IDLE : ST_SETTLE;
            end else begin
                case (state_q)
                    ST_SETTLE: begin
                        cnt_q <= cnt_d;
                        if (cnt_d == STABLE_LAST) begin
                            state_q <= ST_DONE;
                            if (sel_low_cnt == 4'd1) begin
                                if (match_blank) begin
                                    for (int i = 0; i < NUM_DIGITS; i++) begin
                                        if (!cur_sel[i]) begin
                                            valid_q[i] <= 1'b0;
`ifdef SEG7_SCAN_READER_DP_EN
                                            dp_q[i]    <= 1'b0;
`endif
                                        end
                                    end
                                end else if (match_hit) begin
                                    for (int i = 0; i < NUM_DIGITS; i++) begin
                                        if (!cur_sel[i]) begin
                                            digits_q[4*i +: 4] <= match_nibble;
                                            valid_q[i]         <= 1'b1;
`ifdef SEG7_SCAN_READER_DP_EN
                                            dp_q[i]            <= ~cur_dp;
`endif
                                        end
                                    end
                                    upd_q     <= 1'b1;
                                    upd_idx_q <= sel_low_idx;
                                end else begin
                                    err_q <= 1'b1;
                                    if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                                end
                            end else begin
                                err_q <= 1'b1;
                                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign digits_out   = digits_q;
    assign digit_valid  = valid_q;
    assign update_pulse = upd_q;
    assign update_idx   = upd_idx_q;
    assign err_pulse    = err_q;
    assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomized scoreboard bench for seg7_scan_reader: the driver predicts events from bus holds,
// a negedge monitor pops and compares them whenever the reader pulses.
module tb_seg7_scan_reader;

    localparam int ND = 4;
    localparam int S  = 8;

    typedef struct {
        bit is_err;
        int idx;
        int nib;
        int cyc;
    } ev_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [6:0]      segs_in = 7'h7F;
    logic [ND-1:0]   dig_sel_n = '1;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0]   digit_valid;
    logic            update_pulse;
    logic [2:0]      update_idx;
    logic            err_pulse;
    logic [7:0]      err_count;
`ifdef SEG7_SCAN_READER_DP_EN
    logic            dp_in = 1'b1;
    logic [ND-1:0]   digit_dp;
`endif

    seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .segs_in      (segs_in),
        .dig_sel_n    (dig_sel_n),
`ifdef SEG7_SCAN_READER_DP_EN
        .dp_in        (dp_in),
        .digit_dp     (digit_dp),
`endif
        .digits_out   (digits_out),
        .digit_valid  (digit_valid),
        .update_pulse (update_pulse),
        .update_idx   (update_idx),
        .err_pulse    (err_pulse),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    logic [6:0] tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int              tests = 0;
    int              fails = 0;
    int              cyc = 0;
    ev_t             exp_q[$];
    ev_t             mon_e;
    logic [4*ND-1:0] digits_m = '0;
    logic [ND-1:0]   valid_m = '0;
    int              err_m = 0;
    logic [ND+6:0]   prev_val = '1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what a fully qualified hold of {sel,segs} must do.
    task automatic model_eval(input logic [ND-1:0] sel, input logic [6:0] segs, input int at_cyc);
        int lows, idx, nib;
        bit found;
        ev_t e;
        lows = 0; idx = 0; nib = 0; found = 0;
        for (int i = 0; i < ND; i++) if (!sel[i]) begin lows++; idx = i; end
        for (int n = 0; n < 16; n++) if (tab[n] == segs) begin found = 1; nib = n; end
        if (lows == 0) return;
        e.cyc = at_cyc; e.idx = idx; e.nib = nib; e.is_err = 0;
        if (lows > 1 || (segs != 7'h7F && !found)) begin
            e.is_err = 1;
            if (err_m < 255) err_m++;
            exp_q.push_back(e);
        end else if (segs == 7'h7F) begin
            valid_m[idx] = 1'b0;
        end else begin
            digits_m[4*idx +: 4] = 4'(nib);
            valid_m[idx] = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive(input logic [ND-1:0] sel, input logic [6:0] segs, input int len);
        @(negedge clk);
        dig_sel_n = sel;
        segs_in   = segs;
        if ({sel, segs} != prev_val && len >= S) model_eval(sel, segs, cyc + 2 + S);
        prev_val = {sel, segs};
        repeat (len - 1) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        drive('1, 7'h7F, S + 6);
        chk({tag, "_digits"}, 32'(digits_out), 32'(digits_m));
        chk({tag, "_valid"}, 32'(digit_valid), 32'(valid_m));
        chk({tag, "_errcnt"}, 32'(err_count), 32'(err_m));
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    function automatic logic [6:0] bad_pattern();
        logic [6:0] p;
        bit ok;
        do begin
            p  = 7'($urandom_range(0, 127));
            ok = (p != 7'h7F);
            for (int n = 0; n < 16; n++) if (tab[n] == p) ok = 0;
        end while (!ok);
        return p;
    endfunction

    task automatic rand_hold();
        logic [ND-1:0] sel;
        logic [6:0]    segs;
        int k, a, b, len;
        do begin
            k    = $urandom_range(0, 9);
            sel  = ~(ND'(1) << $urandom_range(0, ND - 1));
            segs = tab[$urandom_range(0, 15)];
            if (k == 6) segs = 7'h7F;
            else if (k == 7) segs = bad_pattern();
            else if (k == 8) begin
                a = $urandom_range(0, ND - 1);
                b = (a + $urandom_range(1, ND - 1)) % ND;
                sel = '1; sel[a] = 1'b0; sel[b] = 1'b0;
            end else if (k == 9) sel = '1;
        end while ({sel, segs} == prev_val);
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, S - 1) : $urandom_range(S, 20);
        drive(sel, segs, len);
    endtask

    always @(negedge clk) begin
        if (reset_n && (update_pulse || err_pulse)) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_pulse: upd=%0b err=%0b idx=%0d at cycle %0d, expected none",
                         update_pulse, err_pulse, update_idx, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_is_err", 32'(err_pulse), 32'(mon_e.is_err));
                chk("pulse_is_upd", 32'(update_pulse), 32'(!mon_e.is_err));
                chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                if (!mon_e.is_err) begin
                    chk("update_idx", 32'(update_idx), 32'(mon_e.idx));
                    chk("written_nibble", 32'(digits_out[4*mon_e.idx +: 4]), 32'(mon_e.nib));
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            tests++; fails++;
            mon_e = exp_q.pop_front();
            $display("FAIL missing_pulse: got none by cycle %0d, expected at cycle %0d", cyc, mon_e.cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'(digits_out), 32'd0);
        chk("rst_valid", 32'(digit_valid), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        chk("rst_pulses", 32'({update_pulse, err_pulse, update_idx}), 32'd0);
        reset_n = 1'b1;

        drive(4'b1110, tab[2], 20);
        check_state("single");

        drive(4'b1110, tab[0], 12);
        drive(4'b1101, tab[10], 12);
        drive(4'b1011, tab[11], 12);
        drive(4'b0111, tab[15], 12);
        check_state("scan");
        chk("scan_literal", 32'(digits_out), 32'hFBA0);

        drive(4'b1101, tab[5], S - 2);
        drive(4'b1011, 7'h7F, 20);
        check_state("blank");
        chk("blank_valid_literal", 32'(digit_valid), 32'b1011);

        drive(4'b1110, 7'b1010101, 20);
        drive(4'b1100, tab[3], 20);
        check_state("errors");

        for (int i = 0; i < 200; i++) rand_hold();
        check_state("random");

        for (int i = 0; i < 150; i++) begin
            drive(4'b1110, 7'b1010101, S);
            drive(4'b1100, tab[3], S);
        end
        check_state("saturate");
        chk("saturate_literal", 32'(err_count), 32'd255);

        @(negedge clk);
        dig_sel_n = 4'b1101;
        segs_in   = tab[9];
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_digits", 32'(digits_out), 32'd0);
        chk("midreset_valid", 32'(digit_valid), 32'd0);
        chk("midreset_errcnt", 32'(err_count), 32'd0);
        digits_m = '0; valid_m = '0; err_m = 0; prev_val = '1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_eval(4'b1101, tab[9], cyc + 2 + S);
        prev_val = {4'b1101, tab[9]};
        repeat (19) @(negedge clk);
        check_state("post_reset");
        chk("post_reset_literal", 32'(digits_out), 32'h0090);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receive-side counterpart of the team's hex-to-7-segment display path.
- Samples an external multiplexed, active-low 7-segment bus: segment lines plus per-digit active-low select lines.
- Waits for each selected pattern to be stable, inverse-decodes it to a hex nibble and stores it in a per-digit register bank.
- Used to read back displays driven by other boards, and as a loopback checker for our own display drivers.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits / select lines (1..8).
- STABLE_CYCLES, 8, consecutive identical synchronized samples required before a capture (2..255).

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- segs_in  in  7  segment lines, active-low. bit0=a … bit6=g; 0 = lit.
- dig_sel_n  in  NUM_DIGITS  digit selects, active-low, expected one-hot-low.
- digits_out  out  4*NUM_DIGITS  captured nibbles; digit i at [4i+3:4i].
- digit_valid  out  NUM_DIGITS  per-digit sticky "holds a decoded value".
- update_pulse  out  1  one-cycle strobe when a digit is written.
- update_idx  out  3  index of the written digit; meaningful only with update_pulse.
- err_pulse  out  1  one-cycle strobe on an unrecognised pattern or an illegal select.
- err_count  out  8  saturating error count.

Behaviour:
- Pattern table, segs g..a, 0=lit:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - BLANK=1111111
- Reset: all outputs 0; synchronizers forced to all-1s (idle bus); state IDLE; counter 0.
- Input capture: segs_in and dig_sel_n pass through 2-flop synchronizers. The synchronized value is {sel,segs}; the previous synchronized value is held in a compare register.
- FSM states: IDLE, SETTLE, DONE.
  - Any cycle where the synchronized value differs from the compare register: counter := 0, state := SETTLE, compare register updated. This applies from any state.
  - In SETTLE with the value unchanged: counter increments. When counter == STABLE_CYCLES-1, evaluate (below) and go to DONE.
  - In DONE: hold, no further action until the value changes. A steady bus yields exactly one event.
  - Value equal to all-deselected (sel all-1s) on entry to SETTLE: go to IDLE, no evaluation.
- Evaluation (sel = synchronized selects):
  - sel exactly one-low at index i and pattern in table: digits_out[i] := nibble; digit_valid[i] := 1; update_pulse = 1; update_idx = i.
  - sel one-low and pattern BLANK: digit_valid[i] := 0; digits_out[i] unchanged; no pulses.
  - sel one-low and pattern not in table: err_pulse = 1; digit unchanged.
  - sel with more than one bit low: err_pulse = 1; no write.
- Latency: new value sampled into sync flop 1 at edge N → update_pulse/err_pulse high during the cycle after edge N+1+STABLE_CYCLES. All outputs are registered.
- err_count increments on every err_pulse and saturates at 255, never wrapping.
- A change during SETTLE restarts counting; glitches shorter than STABLE_CYCLES produce no event.
- reset_n asserted mid-SETTLE: immediate return to the reset state; a partial capture is discarded.

Optional Feature:
- Macro: SEG7_SCAN_READER_DP_EN.
- Defined:
  - Adds input dp_in (1 bit, active-low), synchronized and compared alongside segs_in.
  - Adds output digit_dp (NUM_DIGITS bits), written with ~dp on a successful write.
  - Cleared on reset and on BLANK capture.
  - DP does not affect table matching.
- Undefined: no dp ports, no dp logic.

Decomposition:
- Shared package seg7_pkg:
  - the 16 pattern constants and SEG7_BLANK;
  - the FSM state typedef;
  - SEG_W=7.
- The display driver side imports the same constants.
- Sub-module seg7_pattern_match:
  - purely combinational;
  - input 7-bit pattern;
  - outputs nibble[3:0], hit, blank.

Test Plan:
- Steady drive of sel=1110, segs=0100100 for 20 cycles → one update_pulse, update_idx=0, digits_out[3:0]=2, digit_valid=0001, err_count=0.
- Scan 4 digits, each held 12 cycles, with values 0,A,b,F → digits_out=16'hFBA0, digit_valid=1111, exactly 4 update_pulses.
- Pattern held only STABLE_CYCLES-2 cycles, then changed → no pulse for it. Pattern 1111111 on digit 2 after a capture → digit_valid[2]=0, digits_out unchanged.
- Pattern 1010101, or sel=1100 with a valid pattern, held 20 cycles → one err_pulse each, err_count increments, no writes. 300 such errors → err_count=255.
- Reset asserted at SETTLE counter=5 → outputs 0 immediately, no pulse. Release and repeat the stable pattern → normal capture at the specified latency.
